// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : sequencer state type and shared constants                |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } seq_state_t;

   localparam logic [31:0] c_nop_inst         = 32'h0000_0013;
   localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_watchdog : 8-bit fetch wait counter, expires after MAX_WAIT  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_watchdog #(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   // Expiry fires in the MAX_WAIT-th consecutive unacknowledged cycle.
   localparam logic [7:0] c_last = 8'(MAX_WAIT - 1);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   assign expire = enable && !clear && (count_q == c_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer : multi-cycle FETCH/EXEC/HALT sequencer owning the PC |
// | optional macro NPC_ALIGN_CHECK_EN traps misaligned targets. rev 1.0|
// +--------------------------------------------------------------------+
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_default_reset_pc,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] inst,
   input  logic [31:0] next_pc,
   input  logic        exec_done,
   input  logic        stall,
   input  logic        halt_req,
   output logic        commit,
   output logic        halted,
   output logic        fetch_fault,
   output logic        misalign_trap,
   output logic [31:0] instret
);

   seq_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic        fetch_fault_q, fetch_fault_d;
   logic        misalign_q, misalign_d;

   logic        in_fetch;
   logic        in_exec;
   logic        commit_w;
   logic        wd_expire;
   logic        target_misaligned;

   // Gating with rst_n keeps the request and commit strobes quiet while reset is held.
   assign in_fetch = rst_n && (state_q == FETCH);
   assign in_exec  = rst_n && (state_q == EXEC);
   assign commit_w = in_exec && exec_done && !stall;

`ifdef NPC_ALIGN_CHECK_EN
   assign target_misaligned = (next_pc[1:0] != 2'b00);
`else
   assign target_misaligned = 1'b0;
`endif

   fetch_watchdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_fetch_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!in_fetch || imem_ack),
      .enable (in_fetch && !imem_ack),
      .expire (wd_expire)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      instret_d     = instret_q;
      fetch_fault_d = fetch_fault_q;
      misalign_d    = misalign_q;
      unique case (state_q)
         FETCH: begin
            if (imem_ack) begin
               inst_d  = imem_rdata;
               state_d = EXEC;
            end else if (wd_expire) begin
               fetch_fault_d = 1'b1;
               state_d       = HALT;
            end
         end
         EXEC: begin
            if (commit_w) begin
               instret_d = instret_q + 32'd1;
               if (target_misaligned) begin
                  misalign_d = 1'b1;
                  state_d    = HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = halt_req ? HALT : FETCH;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         inst_q        <= c_nop_inst;
         instret_q     <= 32'd0;
         fetch_fault_q <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         instret_q     <= instret_d;
         fetch_fault_q <= fetch_fault_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem_req      = in_fetch;
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign inst          = inst_q;
   assign instret       = instret_q;
   assign commit        = commit_w;
   assign halted        = (state_q == HALT);
   assign fetch_fault   = fetch_fault_q;
   assign misalign_trap = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_sequencer : randomized self-checking bench for pc_sequencer  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_sequencer;

   localparam logic [31:0] c_reset_pc = 32'h0000_0000;
   localparam int          c_max_wait = 4;
   localparam logic [31:0] c_nop      = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] next_pc;
   logic        exec_done;
   logic        stall;
   logic        halt_req;
   logic        commit;
   logic        halted;
   logic        fetch_fault;
   logic        misalign_trap;
   logic [31:0] instret;

   int          checks;
   int          errors;

   // Architectural view expected by the bench, updated per retired instruction.
   logic [31:0] m_pc;
   logic [31:0] m_instret;
   logic [31:0] m_inst;
   bit          m_halted;
   bit          m_trap;

   pc_sequencer #(
      .RESET_PC (c_reset_pc),
      .MAX_WAIT (c_max_wait)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .inst          (inst),
      .next_pc       (next_pc),
      .exec_done     (exec_done),
      .stall         (stall),
      .halt_req      (halt_req),
      .commit        (commit),
      .halted        (halted),
      .fetch_fault   (fetch_fault),
      .misalign_trap (misalign_trap),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      exec_done  = 1'b0;
      stall      = 1'b0;
      halt_req   = 1'b0;
      next_pc    = 32'h0;
      tick();
      rst_n     = 1'b1;
      m_pc      = c_reset_pc;
      m_instret = 32'd0;
      m_inst    = c_nop;
      m_halted  = 1'b0;
      m_trap    = 1'b0;
   endtask

   // One full instruction: 'waits' unacked fetch cycles, 'hold' non-commit EXEC cycles.
   task automatic run_instr(input int waits, input int hold, input bit stall_only,
                            input logic [31:0] npc, input bit hlt, input logic [31:0] word);
      for (int i = 0; i <= waits; i++) begin
         imem_ack   = (i == waits);
         imem_rdata = (i == waits) ? word : $urandom;
         exec_done  = 1'($urandom);
         stall      = 1'($urandom);
         halt_req   = 1'($urandom);
         next_pc    = $urandom;
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc || commit !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle: req=%b addr=%h commit=%b, required req=1 addr=%h commit=0",
                     imem_req, imem_addr, commit, m_pc);
         end
         tick();
      end
      m_inst = word;
      for (int i = 0; i <= hold; i++) begin
         int r;
         r          = $urandom_range(0, 2);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         if (i == hold) begin
            exec_done = 1'b1;
            stall     = 1'b0;
            halt_req  = hlt;
            next_pc   = npc;
         end else begin
            if (stall_only) r = 1;
            exec_done = (r == 1);
            stall     = (r != 0);
            halt_req  = 1'($urandom);
            next_pc   = $urandom;
         end
         #1;
         checks++;
         if (imem_req !== 1'b0 || inst !== m_inst || pc !== m_pc || commit !== (i == hold)) begin
            errors++;
            $display("FAIL exec_cycle: req=%b inst=%h pc=%h commit=%b, required req=0 inst=%h pc=%h commit=%b",
                     imem_req, inst, pc, commit, m_inst, m_pc, (i == hold));
         end
         tick();
      end
      imem_ack  = 1'b0;
      m_instret = m_instret + 32'd1;
`ifdef NPC_ALIGN_CHECK_EN
      if (npc[1:0] != 2'b00) begin
         m_trap   = 1'b1;
         m_halted = 1'b1;
      end else begin
         m_pc = npc;
         if (hlt) m_halted = 1'b1;
      end
`else
      m_pc = npc;
      if (hlt) m_halted = 1'b1;
`endif
      checks++;
      if (pc !== m_pc || instret !== m_instret) begin
         errors++;
         $display("FAIL retire: pc=%h instret=%0d, required pc=%h instret=%0d", pc, instret, m_pc, m_instret);
      end
      checks++;
      if (halted !== m_halted || misalign_trap !== m_trap || fetch_fault !== 1'b0
          || imem_req !== !m_halted) begin
         errors++;
         $display("FAIL retire_flags: halted=%b trap=%b fault=%b req=%b, required halted=%b trap=%b fault=0 req=%b",
                  halted, misalign_trap, fetch_fault, imem_req, m_halted, m_trap, !m_halted);
      end
   endtask

   task automatic check_frozen(input int n, input bit fault);
      for (int i = 0; i < n; i++) begin
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         exec_done  = 1'b1;
         stall      = 1'b0;
         halt_req   = 1'($urandom);
         next_pc    = $urandom;
         #1;
         checks++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || commit !== 1'b0 || pc !== m_pc
             || instret !== m_instret || fetch_fault !== fault || misalign_trap !== m_trap) begin
            errors++;
            $display("FAIL halt_frozen: halted=%b req=%b commit=%b pc=%h instret=%0d fault=%b, required 1 0 0 pc=%h instret=%0d fault=%b",
                     halted, imem_req, commit, pc, instret, fetch_fault, m_pc, m_instret, fault);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || commit !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: req=%b commit=%b, required 0 0", imem_req, commit);
      end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (pc !== c_reset_pc || instret !== 32'd0 || inst !== c_nop || imem_req !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: pc=%h instret=%0d inst=%h req=%b, required %h 0 %h 1",
                  pc, instret, inst, imem_req, c_reset_pc, c_nop);
      end
      checks++;
      if (halted !== 1'b0 || fetch_fault !== 1'b0 || misalign_trap !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: halted=%b fault=%b trap=%b, required 0 0 0",
                  halted, fetch_fault, misalign_trap);
      end
   endtask

   task automatic test_zero_wait();
      do_reset();
      for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b0, m_pc + 32'd4, 1'b0, $urandom);
      checks++;
      if (pc !== 32'd12 || instret !== 32'd3) begin
         errors++;
         $display("FAIL zero_wait: pc=%h instret=%0d, required 0000000c 3", pc, instret);
      end
   endtask

   task automatic test_fetch_wait();
      do_reset();
      run_instr(3, 0, 1'b0, m_pc + 32'd4, 1'b0, 32'hDEAD_BEEF);
      run_instr(c_max_wait - 1, 1, 1'b0, m_pc + 32'd8, 1'b0, 32'h1234_5678);
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 25; k++) begin
         run_instr($urandom_range(0, c_max_wait - 1), $urandom_range(0, 3), 1'b0,
                   {$urandom} & 32'hFFFF_FFFC, 1'b0, $urandom);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < c_max_wait; i++) begin
         imem_ack  = 1'b0;
         exec_done = 1'($urandom);
         stall     = 1'($urandom);
         #1;
         checks++;
         if (imem_req !== 1'b1 || halted !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait: req=%b halted=%b fault=%b, required 1 0 0",
                     imem_req, halted, fetch_fault);
         end
         tick();
      end
      check_frozen(3, 1'b1);
   endtask

   task automatic test_stall_halt();
      do_reset();
      run_instr(0, 0, 1'b0, 32'h0000_0004, 1'b0, $urandom);
      run_instr(1, 2, 1'b1, 32'h0000_0200, 1'b1, $urandom);
      check_frozen(4, 1'b0);
   endtask

   task automatic test_misalign();
      do_reset();
      run_instr(0, 0, 1'b0, 32'h0000_0004, 1'b0, $urandom);
      run_instr(0, 1, 1'b0, 32'h0000_0102, 1'b0, $urandom);
`ifdef NPC_ALIGN_CHECK_EN
      check_frozen(3, 1'b0);
`else
      run_instr(0, 0, 1'b0, 32'h0000_0300, 1'b0, $urandom);
`endif
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      run_instr(0, 0, 1'b0, 32'h0000_0010, 1'b0, $urandom);
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      tick();
      imem_ack  = 1'b0;
      exec_done = 1'b1;
      stall     = 1'b0;
      rst_n     = 1'b0;
      #1;
      checks++;
      if (commit !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_exec_strobe: commit=%b req=%b, required 0 0", commit, imem_req);
      end
      tick();
      rst_n     = 1'b1;
      exec_done = 1'b0;
      #1;
      checks++;
      if (pc !== c_reset_pc || instret !== 32'd0 || imem_req !== 1'b1 || inst !== c_nop) begin
         errors++;
         $display("FAIL reset_exec_state: pc=%h instret=%0d req=%b inst=%h, required %h 0 1 %h",
                  pc, instret, imem_req, inst, c_reset_pc, c_nop);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_zero_wait();
      test_fetch_wait();
      test_random();
      test_timeout();
      test_stall_halt();
      test_misalign();
      test_reset_mid_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the RV32I core. It owns the architectural PC register, issues instruction fetches over a simple req/ack port, and holds the fetched instruction while the datapath executes. On completion it commits the target computed by the NPC unit. It sits between instruction memory, the NPC unit (drives its `PC` input, consumes its `next_pc` output) and the datapath control, which it gates with a one-cycle commit strobe.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MAX_WAIT`, 16, fetch wait cycles tolerated before a fetch fault (range 1..255).
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: fetch request, high in FETCH state only.
- `imem_addr` out 32: fetch address, always equals `pc`.
- `imem_ack` in 1: instruction valid; meaningful only while `imem_req`=1.
- `imem_rdata` in 32: instruction word, sampled when `imem_req && imem_ack`.
- `pc` out 32: current PC, feeds NPC `PC`.
- `inst` out 32: latched instruction for decode.
- `next_pc` in 32: NPC output, sampled on the commit cycle.
- `exec_done` in 1: datapath finished the current instruction (multi-cycle loads/stores hold it low).
- `stall` in 1: external hold; overrides `exec_done`.
- `halt_req` in 1: decoded EBREAK/halt, sampled on the commit cycle.
- `commit` out 1: one-cycle pulse enabling register-file and data-memory writes.
- `halted` out 1: sticky, sequencer stopped.
- `fetch_fault` out 1: sticky, fetch timed out.
- `misalign_trap` out 1: sticky, misaligned target (see Configuration).
- `instret` out 32: retired-instruction counter.

## Operation
- States: FETCH, EXEC, HALT.
- FETCH: `imem_req`=1. On `imem_ack` latch `imem_rdata` into `inst`, clear the wait counter, go to EXEC. Otherwise increment the wait counter. When the count reaches `MAX_WAIT` with no ack: set `fetch_fault`, go to HALT, leave `pc` unchanged.
- EXEC: `imem_req`=0. Commit condition is `exec_done && !stall`. On commit:
  - `commit`=1 combinationally in that cycle.
  - `pc` <= `next_pc`; `instret` <= `instret`+1, wrapping mod 2^32.
  - If `halt_req`=1, go to HALT; else go to FETCH.
- HALT: all strobes 0, `halted`=1, state frozen. Only reset exits.
- A halting instruction is retired: it is counted, and `pc` advances to `next_pc`.
- `halt_req` is ignored outside the commit cycle.
- `stall` in FETCH has no effect: an in-flight fetch completes.
- `inst` is held stable through all of EXEC.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state=FETCH, `pc`=`RESET_PC`, `inst`=32'h0000_0013 (NOP).
  - `instret`=0; `commit`, `halted`, `fetch_fault`, `misalign_trap` = 0.
  - Wait counter = 0.
  - `imem_req`=0 while `rst_n`=0.
- First request is in the first cycle after `rst_n` rises.
- Reset mid-fetch or mid-EXEC discards the instruction with no commit. Memory must drop any pending ack when `imem_req` falls.
- Zero-wait memory (ack in the request cycle) gives a minimum of 2 cycles per instruction: FETCH, then EXEC with `exec_done`=1.
- Each wait cycle in FETCH and each `stall` or `!exec_done` cycle in EXEC adds exactly one cycle.
- `pc` and `instret` are updated at the edge ending the commit cycle and are visible in the next cycle.

## Configuration
- `NPC_ALIGN_CHECK_EN` defined:
  - On a commit cycle with `next_pc[1:0]`!=0, `commit` is still 1 (the instruction retires) and `instret` increments.
  - `pc` keeps the faulting instruction's address, `misalign_trap` is set, and the state goes to HALT.
- `NPC_ALIGN_CHECK_EN` undefined: `pc` <= `next_pc` unchanged, and `misalign_trap` is tied 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum typedef (FETCH/EXEC/HALT);
  - the NOP constant 32'h0000_0013;
  - the default reset vector constant.
- One sub-module, `fetch_watchdog`: an 8-bit wait counter with clear/enable inputs and an expire output, compared against `MAX_WAIT`.
- FSM, PC register, instruction register and `instret` stay in the top module.

## Test plan
- Zero-wait fetch: ack same cycle, `exec_done`=1, `next_pc`=`pc`+4 from 0 → `pc` steps 0,4,8 every 2 cycles; `commit` pulses every 2nd cycle; `instret`=3 after 6 cycles.
- Fetch wait: ack after 3 cycles → `inst` latched on the ack edge; no commit before EXEC.
- Timeout with `MAX_WAIT`=4 and no ack → `fetch_fault`=1 and `halted`=1 after 4 FETCH cycles; `pc` unchanged.
- Stall and halt:
  - `exec_done`=1 with `stall`=1 for 2 cycles → no commit, `pc` held.
  - Then `halt_req`=1 at commit → `instret` increments, `pc`=`next_pc`, HALT entered.
- Misalign (macro on): `next_pc`=32'h0000_0102 → `commit`=1, `misalign_trap`=1, `pc` held, HALT.
- Misalign (macro off): the same stimulus gives `pc`=32'h0000_0102.
- Reset mid-EXEC → next cycle `pc`=`RESET_PC`, `instret`=0, `imem_req`=1, `inst`=NOP.
